// File: rtl/perip_pwm_multi.sv
// Multi-channel PWM generator driven by one shared period counter.
// Period, duty, polarity and breathing enables are double-buffered and change only at a period wrap.
module perip_pwm_multi #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    EN,
    input  logic [CNT_W-1:0]        FREQ_Cnt_Set,
    input  logic [CH_NUM*CNT_W-1:0] DUTY_Set,
    input  logic [CH_NUM-1:0]       POL_Set,
    input  logic [CH_NUM-1:0]       BREATH_En,
    input  logic [CNT_W-1:0]        BREATH_Step,
    input  logic                    UPDATE,
    output logic [CH_NUM-1:0]       PWM_Out,
    output logic                    PERIOD_Tick,
    output logic                    UPD_Done
);

    // Per-channel breathing ramp direction:
    //   state    | meaning
    //   DIR_UP   | duty grows by the step each wrap until it saturates at period+1
    //   DIR_DOWN | duty shrinks by the step each wrap until it saturates at 0
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    logic [CNT_W-1:0]               per_q;
    logic [CNT_W-1:0]               per_d;
    logic [CH_NUM-1:0][CNT_W-1:0]   duty_q;
    logic [CH_NUM-1:0][CNT_W-1:0]   duty_d;
    logic [CH_NUM-1:0]              pol_q;
    logic [CH_NUM-1:0]              pol_d;
    logic [CH_NUM-1:0]              brt_en_q;
    logic [CH_NUM-1:0]              brt_en_d;
    logic [CH_NUM-1:0][CNT_W:0]     brt_q;
    logic [CH_NUM-1:0][CNT_W:0]     brt_d;
    dir_t                           dir_q [CH_NUM];
    dir_t                           dir_d [CH_NUM];
    logic                           pend_q;
    logic                           pend_d;
    logic [CH_NUM-1:0]              pwm_q;
    logic [CH_NUM-1:0]              pwm_d;
    logic [CH_NUM-1:0][CNT_W:0]     deff;
    logic                           wrap;
    logic                           load;
    logic [CNT_W:0]                 brt_lim;
    logic [CNT_W:0]                 step_x;

    // Reset gating keeps the pulses low while the block is held in reset.
    assign wrap = RST_n & EN & (cnt_q >= per_q);
    assign load = wrap & (pend_q | UPDATE);

    assign PERIOD_Tick = wrap;
    assign UPD_Done    = load;
    assign PWM_Out     = pwm_q;

    always_comb begin
        per_d    = per_q;
        duty_d   = duty_q;
        pol_d    = pol_q;
        brt_en_d = brt_en_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;

        if (load) begin
            per_d    = FREQ_Cnt_Set;
            duty_d   = DUTY_Set;
            pol_d    = POL_Set;
            brt_en_d = BREATH_En;
        end

        if (load) begin
            pend_d = 1'b0;
        end else if (UPDATE) begin
            pend_d = 1'b1;
        end

        if (!EN || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Ramp limits follow the settings that will be in force for the coming period.
    assign brt_lim = {1'b0, per_d} + {{CNT_W{1'b0}}, 1'b1};
    assign step_x  = {1'b0, BREATH_Step};

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            brt_d[i] = brt_q[i];
            dir_d[i] = dir_q[i];
            if (wrap) begin
                if (!brt_en_d[i]) begin
                    brt_d[i] = '0;
                    dir_d[i] = DIR_UP;
                end else if (step_x != '0) begin
                    if (dir_q[i] == DIR_UP) begin
                        // Compare against lim-step so the sum never needs an extra bit.
                        if ((step_x >= brt_lim) || (brt_q[i] >= (brt_lim - step_x))) begin
                            brt_d[i] = brt_lim;
                            dir_d[i] = DIR_DOWN;
                        end else begin
                            brt_d[i] = brt_q[i] + step_x;
                        end
                    end else begin
                        if (brt_q[i] <= step_x) begin
                            brt_d[i] = '0;
                            dir_d[i] = DIR_UP;
                        end else begin
                            brt_d[i] = brt_q[i] - step_x;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            deff[i]  = brt_en_q[i] ? brt_q[i] : {1'b0, duty_q[i]};
            pwm_d[i] = pol_q[i];
            if (EN) begin
                pwm_d[i] = ({1'b0, cnt_q} < deff[i]) ^ pol_q[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q    <= '0;
            per_q    <= '0;
            duty_q   <= '0;
            pol_q    <= '1;
            brt_en_q <= '0;
            brt_q    <= '0;
            pend_q   <= 1'b0;
            pwm_q    <= '1;
            for (int i = 0; i < CH_NUM; i++) begin
                dir_q[i] <= DIR_UP;
            end
        end else begin
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            pol_q    <= pol_d;
            brt_en_q <= brt_en_d;
            brt_q    <= brt_d;
            pend_q   <= pend_d;
            pwm_q    <= pwm_d;
            for (int i = 0; i < CH_NUM; i++) begin
                dir_q[i] <= dir_d[i];
            end
        end
    end

endmodule

// File: tb/tb_perip_pwm_multi.sv
// Directed bench for perip_pwm_multi: expected waveforms are queued when stimulus
// is applied and compared against recorded output history once it exists.
module tb_perip_pwm_multi;
    localparam int CH   = 4;
    localparam int W    = 32;
    localparam int HMAX = 4096;

    logic            CLK = 1'b0;
    logic            RST_n;
    logic            EN;
    logic            UPDATE;
    logic [W-1:0]    FREQ_Cnt_Set;
    logic [W-1:0]    BREATH_Step;
    logic [CH*W-1:0] DUTY_Set;
    logic [CH-1:0]   POL_Set;
    logic [CH-1:0]   BREATH_En;
    logic [CH-1:0]   PWM_Out;
    logic            PERIOD_Tick;
    logic            UPD_Done;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t           sbq[$];
    int            n_pass    = 0;
    int            n_total   = 0;
    int            cyc       = 0;
    int            upd_count = 0;
    int            last_upd  = -1;
    logic [CH-1:0] pwm_h  [HMAX];
    logic          tick_h [HMAX];
    logic [W-1:0]  duty   [CH];

    perip_pwm_multi #(.CH_NUM(CH), .CNT_W(W)) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .EN           (EN),
        .FREQ_Cnt_Set (FREQ_Cnt_Set),
        .DUTY_Set     (DUTY_Set),
        .POL_Set      (POL_Set),
        .BREATH_En    (BREATH_En),
        .BREATH_Step  (BREATH_Step),
        .UPDATE       (UPDATE),
        .PWM_Out      (PWM_Out),
        .PERIOD_Tick  (PERIOD_Tick),
        .UPD_Done     (UPD_Done)
    );

    always #5 CLK = ~CLK;

    // History is captured mid-cycle; index cyc names the cycle that began at the previous rising edge.
    always @(negedge CLK) begin
        if (cyc < HMAX) begin
            pwm_h[cyc]  <= PWM_Out;
            tick_h[cyc] <= PERIOD_Tick;
        end
        if (UPD_Done) begin
            upd_count <= upd_count + 1;
            last_upd  <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        sb_t e;
        n_total++;
        if (sbq.size() == 0) begin
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic apply_duty();
        for (int i = 0; i < CH; i++) DUTY_Set[i*W +: W] = duty[i];
    endtask

    task automatic pulse_update(output int start);
        start  = upd_count;
        UPDATE = 1'b1;
        go();
        UPDATE = 1'b0;
    endtask

    task automatic wait_upd(input int start, input int budget);
        int n = 0;
        while (upd_count == start && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (upd_count == start) begin
            n_total++;
            $error("FAIL upd_timeout observed=no UPD_Done expected=pulse within %0d cycles", budget);
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc <= target && n < 5000) begin
            go();
            n++;
        end
        if (cyc <= target) begin
            n_total++;
            $error("FAIL cyc_timeout observed=%0d expected=>%0d", cyc, target);
        end
    endtask

    task automatic wait_phase(input int base, input int per, input int ph);
        int n = 0;
        while (((cyc - base) % per) != ph && n < 1000) begin
            go();
            n++;
        end
    endtask

    // Ideal one-period waveform: bit j is the pin level for counter value j.
    function automatic logic [63:0] exp_pat(input logic [W-1:0] d, input int p, input logic pol);
        logic [63:0] r = '0;
        for (int j = 0; j <= p; j++) r[j] = ((W'(j) < d) ? 1'b1 : 1'b0) ^ pol;
        return r;
    endfunction

    function automatic logic [63:0] pat(input int ch, input int first, input int len);
        logic [63:0] r = '0;
        for (int j = 0; j < len; j++) if (first + j < HMAX && first + j >= 0) r[j] = pwm_h[first+j][ch];
        return r;
    endfunction

    function automatic logic [63:0] tick_pat(input int first, input int len);
        logic [63:0] r = '0;
        for (int j = 0; j < len; j++) if (first + j < HMAX && first + j >= 0) r[j] = tick_h[first+j];
        return r;
    endfunction

    initial begin
        int u;
        int w;
        int w2;
        int x;
        int y;
        int st;
        int bseq [7];
        bseq = '{4, 8, 10, 6, 2, 0, 4};

        RST_n        = 1'b0;
        EN           = 1'b0;
        UPDATE       = 1'b0;
        FREQ_Cnt_Set = '0;
        BREATH_Step  = '0;
        POL_Set      = '0;
        BREATH_En    = '0;
        for (int i = 0; i < CH; i++) duty[i] = '0;
        apply_duty();
        go();
        go();
        push("rst_pwm", 64'hF);
        push("rst_tick", 64'h0);
        push("rst_upd", 64'h0);
        sb_check(64'(PWM_Out));
        sb_check(64'(PERIOD_Tick));
        sb_check(64'(UPD_Done));
        RST_n = 1'b1;
        go();
        go();

        // Basic duty, constant-level boundaries, and an UPDATE landing on a wrap.
        FREQ_Cnt_Set = 9;
        duty[0] = 3; duty[1] = 0; duty[2] = 10; duty[3] = 32'hFFFF;
        apply_duty();
        POL_Set = 4'b0000;
        EN      = 1'b1;
        x       = cyc;
        push("load_same_wrap", 64'(x));
        push("ch0_d3", exp_pat(3, 9, 1'b0));
        push("ch1_d0", exp_pat(0, 9, 1'b0));
        push("ch2_d10", exp_pat(10, 9, 1'b0));
        push("ch3_dffff", exp_pat(32'hFFFF, 9, 1'b0));
        push("tick_p10", 64'((1 << 9) | (1 << 19)));
        pulse_update(st);
        wait_upd(st, 20);
        u = last_upd;
        sb_check(64'(u));
        wait_cyc(u + 21);
        sb_check(pat(0, u + 2, 10));
        sb_check(pat(1, u + 2, 10));
        sb_check(pat(2, u + 2, 10));
        sb_check(pat(3, u + 2, 10));
        sb_check(tick_pat(u + 1, 20));

        // Live duty change without UPDATE, then UPDATE mid-period.
        duty[0] = 7;
        apply_duty();
        push("no_upd_keep", exp_pat(3, 9, 1'b0));
        wait_cyc(u + 42);
        sb_check(pat(0, u + 32, 10));
        wait_phase(u + 1, 10, 4);
        x = cyc;
        push("upd_at_wrap", 64'(x + 5));
        push("old_duty_tail", exp_pat(3, 9, 1'b0));
        push("new_duty", exp_pat(7, 9, 1'b0));
        pulse_update(st);
        wait_upd(st, 30);
        w = last_upd;
        sb_check(64'(w));
        wait_cyc(w + 12);
        sb_check(pat(0, w - 8, 10));
        sb_check(pat(0, w + 2, 10));

        // Inverted polarity on every boundary case.
        POL_Set = 4'b1111;
        push("pol_ch0", exp_pat(7, 9, 1'b1));
        push("pol_ch1", exp_pat(0, 9, 1'b1));
        push("pol_ch2", exp_pat(10, 9, 1'b1));
        push("pol_ch3", exp_pat(32'hFFFF, 9, 1'b1));
        pulse_update(st);
        wait_upd(st, 30);
        w = last_upd;
        wait_cyc(w + 12);
        for (int c = 0; c < CH; c++) sb_check(pat(c, w + 2, 10));

        // Period of one cycle.
        FREQ_Cnt_Set = 0;
        push("p0_tick", 64'hFF);
        pulse_update(st);
        wait_upd(st, 30);
        w = last_upd;
        wait_cyc(w + 9);
        sb_check(tick_pat(w + 1, 8));

        // Breathing ramp on channel 0.
        FREQ_Cnt_Set = 9;
        BREATH_Step  = 4;
        BREATH_En    = 4'b0001;
        POL_Set      = 4'b0000;
        for (int k = 0; k < 7; k++) push($sformatf("breath_%0d", k), exp_pat(bseq[k], 9, 1'b0));
        pulse_update(st);
        wait_upd(st, 10);
        w = last_upd;
        wait_cyc(w + 72);
        for (int k = 0; k < 7; k++) sb_check(pat(0, w + 2 + 10 * k, 10));

        // Shrinking the period from 99 to 5 mid-period.
        FREQ_Cnt_Set = 99;
        BREATH_En    = 4'b0000;
        duty[0]      = 3;
        apply_duty();
        pulse_update(st);
        wait_upd(st, 30);
        w = last_upd;
        wait_cyc(w + 50);
        FREQ_Cnt_Set = 5;
        push("upd_cnt99", 64'(w + 100));
        push("tick_p6", 64'(1 | (1 << 6) | (1 << 12)));
        pulse_update(st);
        wait_upd(st, 80);
        w2 = last_upd;
        sb_check(64'(w2));
        wait_cyc(w + 113);
        sb_check(tick_pat(w + 100, 13));

        // Global disable: inactive levels, counter held, pending load retained.
        POL_Set = 4'b1010;
        pulse_update(st);
        wait_upd(st, 20);
        w = last_upd;
        wait_phase(w + 1, 6, 2);
        x  = cyc;
        EN = 1'b0;
        push("en0_pwm", 64'h0A);
        push("en0_tick", 64'h0);
        wait_cyc(x + 3);
        sb_check(64'(pwm_h[x+1]));
        sb_check(tick_pat(x, 3));
        FREQ_Cnt_Set = 3;
        pulse_update(st);
        go();
        y  = cyc;
        EN = 1'b1;
        push("pend_after_en", 64'(y + 5));
        push("tick_after_en", 64'((1 << 5) | (1 << 9)));
        wait_cyc(y + 10);
        sb_check(64'(last_upd));
        sb_check(tick_pat(y, 10));

        // Asynchronous reset between clock edges.
        go();
        RST_n = 1'b0;
        #1;
        push("rst_async_pwm", 64'hF);
        push("rst_async_tick", 64'h0);
        push("rst_async_upd", 64'h0);
        sb_check(64'(PWM_Out));
        sb_check(64'(PERIOD_Tick));
        sb_check(64'(UPD_Done));
        go();
        RST_n = 1'b1;
        go();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
